lifo_pop_streamer: RTL and testbench
====================================

// Module: lifo_pop_streamer
// PURPOSE
//  Downstream consumer of the LIFO: on a start command, pops up to a requested number of words
//  (or until empty) and presents them on a valid/ready stream. Hides the LIFO's 1-cycle read
//  latency with a 2-entry skid buffer. Sustains one word per cycle while the sink is ready.
// PARAMETERS
//  DWIDTH   8  data word width; matches the LIFO's DWIDTH
//  AWIDTH   3  LIFO address width; burst counter is AWIDTH+1 bits (max 2**AWIDTH words)
// PORTS
//  clk_i          in   1           clock
//  srst_i         in   1           synchronous reset, active-high
//  start_i        in   1           start a drain burst; ignored unless busy_o==0
//  burst_len_i    in   AWIDTH+1    words to pop; 0 = pop until LIFO empty; sampled when start_i accepted
//  lifo_empty_i   in   1           LIFO empty flag (registered; reflects pops issued up to the previous cycle)
//  lifo_q_i       in   DWIDTH      LIFO read data, valid the cycle after lifo_rdreq_o
//  lifo_rdreq_o   out  1           pop request to the LIFO
//  out_data_o     out  DWIDTH      stream data
//  out_valid_o    out  1           stream valid
//  out_ready_i    in   1           stream ready; word transfers when valid & ready
//  busy_o         out  1           burst in progress
//  done_o         out  1           1-cycle pulse: burst finished, all popped words delivered
//  popped_o       out  AWIDTH+1    words popped in the current/last burst
// BEHAVIOUR
//  - Reset: every output is 0; FSM -> IDLE; skid buffer emptied; any in-flight LIFO word discarded.
//  - FSM in lifo_pkg::pop_state_t:
//      IDLE  -> DRAIN on start_i: latch burst_len_i; clear popped_o.
//      DRAIN -> FLUSH when remaining==0 (non-zero burst) or lifo_empty_i==1.
//      FLUSH -> IDLE when no read is in flight and the skid buffer is empty; done_o pulses that cycle.
//  - busy_o = (state != IDLE). start_i during busy is ignored. start_i on the done_o cycle is also
//    ignored; a new burst is accepted from the next cycle.
//  - lifo_rdreq_o = DRAIN & !lifo_empty_i & (remaining != 0 | burst_len == 0)
//                   & (skid occupancy + in_flight + 1 <= 2), with in_flight = rdreq of the previous cycle.
//    - The credit rule prevents overflow of the skid buffer under backpressure.
//    - The credit rule is evaluated on registered state only; no combinational path from out_ready_i
//      to lifo_rdreq_o.
//  - Read latency: lifo_q_i is written into the skid buffer the cycle after lifo_rdreq_o.
//    - Word is visible on out_data_o the same cycle if the buffer was empty (first-word latency:
//      start -> valid = 2 cycles).
//  - Stream: out_valid_o stays high and out_data_o stays stable until the handshake.
//    - Order is strictly pop order, i.e. LIFO order: last written word first.
//  - Counters:
//    - popped_o increments on each rdreq and saturates at 2**AWIDTH.
//    - remaining decrements on each rdreq and never underflows.
//  - Empty mid-burst (burst_len > available words) ends the burst early; popped_o reports the actual count.
//  - Simultaneous push into LIFO while draining is legal; empty flag is simply re-evaluated each cycle.
//  - srst_i mid-burst aborts immediately. No done_o pulse; already-popped words are lost.
// CONFIGURATION
//  LIFO_POP_LAST_EN:
//    - Defined: adds output out_last_o (1 bit), high with the final word of a burst (remaining hit 0,
//      or empty detected with no further pops in flight), qualified by out_valid_o. Stored per skid entry.
//    - Undefined: port absent; no extra storage.
// STRUCTURE
//  - lifo_pkg: pop_state_t enum {IDLE, DRAIN, FLUSH}; localparam SKID_DEPTH = 2.
//  - Sub-module lifo_skid_buf (DWIDTH, 2 entries, wr_i/data_i, valid/ready out, occupancy_o).
//  - FSM, counters and credit logic live in the top.
// TESTING
//  1. LIFO holds 1,2,3 (3 pushed last); start, len=3, ready=1 -> stream 3,2,1 back-to-back; done_o once; popped_o=3.
//  2. 8 words, len=0, out_ready_i toggles 1/0 each cycle -> all 8 delivered in LIFO order, no loss/duplication;
//     rdreq never exceeds credit.
//  3. 2 words, len=5 -> 2 words delivered, early FLUSH, done_o, popped_o=2.
//  4. out_ready_i=0 for 10 cycles after start -> exactly 2 pops issued; data held stable; resume drains the rest.
//  5. srst_i asserted with one word in skid and one in flight -> next cycle all outputs 0, FSM IDLE, no done_o.
//  6. LIFO_POP_LAST_EN defined, len=4 -> out_last_o high only on the 4th handshake; start_i while busy ignored.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared types and sizing for the LIFO pop streamer.
// Optional feature macro: LIFO_POP_LAST_EN (adds a per-word last flag on the output stream).
package lifo_pkg;

   // Pop streamer control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } pop_state_t;

   // Skid buffer depth and the width needed to count 0..SKID_DEPTH entries
   localparam int unsigned SKID_DEPTH = 2;
   localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage : lifo_pkg

// File: rtl/lifo_skid_buf.sv
// Two-entry skid buffer with same-cycle bypass: a word written while the buffer
// is empty is presented immediately and only stored if the sink does not take it.
module lifo_skid_buf
   import lifo_pkg::*;
#(
   parameter int unsigned DWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              wr_i,
   input  logic [DWIDTH-1:0] data_i,
   output logic              valid_o,
   output logic [DWIDTH-1:0] data_o,
   input  logic              ready_i,
   output logic [OCC_W-1:0]  occupancy_o
);

   logic [DWIDTH-1:0] ent0_q, ent0_d;
   logic [DWIDTH-1:0] ent1_q, ent1_d;
   logic [OCC_W-1:0]  occ_q,  occ_d;
   logic              take;

   // Head selection, handshake and entry/occupancy update
   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      occ_d   = occ_q;
      valid_o = (occ_q != '0) | wr_i;
      data_o  = '0;
      if (occ_q != '0) begin
         data_o = ent0_q;
      end else if (wr_i) begin
         data_o = data_i;
      end
      take = valid_o & ready_i;

      case (occ_q)
         OCC_W'(0): begin
            if (wr_i && !ready_i) begin
               ent0_d = data_i;
               occ_d  = OCC_W'(1);
            end
         end
         OCC_W'(1): begin
            if (take) begin
               if (wr_i) begin
                  ent0_d = data_i;
               end else begin
                  occ_d = OCC_W'(0);
               end
            end else if (wr_i) begin
               ent1_d = data_i;
               occ_d  = OCC_W'(2);
            end
         end
         default: begin
            if (take) begin
               ent0_d = ent1_q;
               if (wr_i) begin
                  ent1_d = data_i;
               end else begin
                  occ_d = OCC_W'(1);
               end
            end
         end
      endcase
   end

   // Entry and occupancy registers
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= '0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end

   assign occupancy_o = occ_q;

endmodule : lifo_skid_buf

// File: rtl/lifo_pop_streamer.sv
// Drains a burst of words from a LIFO onto a valid/ready stream, hiding the
// LIFO read latency with a credit-controlled two-entry skid buffer.
// Optional feature macro: LIFO_POP_LAST_EN (adds out_last_o, stored per skid entry).
module lifo_pop_streamer
   import lifo_pkg::*;
#(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned AWIDTH = 3
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              start_i,
   input  logic [AWIDTH:0]   burst_len_i,
   input  logic              lifo_empty_i,
   input  logic [DWIDTH-1:0] lifo_q_i,
   output logic              lifo_rdreq_o,
   output logic [DWIDTH-1:0] out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
`ifdef LIFO_POP_LAST_EN
   output logic              out_last_o,
`endif
   output logic              busy_o,
   output logic              done_o,
   output logic [AWIDTH:0]   popped_o
);

   localparam int unsigned CW = AWIDTH + 1;
   localparam logic [CW-1:0] MAX_POP = CW'(1) << AWIDTH;
`ifdef LIFO_POP_LAST_EN
   localparam int unsigned SW = DWIDTH + 1;
`else
   localparam int unsigned SW = DWIDTH;
`endif

   pop_state_t        state_q, state_d;
   logic [CW-1:0]     burst_len_q, burst_len_d;
   logic [CW-1:0]     remaining_q, remaining_d;
   logic [CW-1:0]     popped_q, popped_d;
   logic              in_flight_q;
   logic              unlimited;
   logic              credit_ok;
   logic              rdreq_c;
   logic              done_c;
   logic [OCC_W-1:0]  skid_occ;
   logic [SW-1:0]     skid_wdata;
   logic [SW-1:0]     skid_rdata;
   logic              skid_valid;

   // Credit check on registered state only: stored words plus the word in flight
   // must leave room for the word about to be requested
   always_comb begin
      unlimited = (burst_len_q == '0);
      credit_ok = (({1'b0, skid_occ} + (OCC_W + 1)'(in_flight_q)) < (OCC_W + 1)'(SKID_DEPTH));
      rdreq_c   = (state_q == DRAIN) & !lifo_empty_i & ((remaining_q != '0) | unlimited)
                  & credit_ok & !srst_i;
      done_c    = (state_q == FLUSH) & !in_flight_q & (skid_occ == '0);
   end

   // Next-state and burst counter logic
   always_comb begin
      state_d     = state_q;
      burst_len_d = burst_len_q;
      remaining_d = remaining_q;
      popped_d    = popped_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d     = DRAIN;
               burst_len_d = burst_len_i;
               remaining_d = burst_len_i;
               popped_d    = '0;
            end
         end
         DRAIN: begin
            if ((!unlimited && (remaining_q == '0)) || lifo_empty_i) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (done_c) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rdreq_c) begin
         if (remaining_q != '0) begin
            remaining_d = remaining_q - CW'(1);
         end
         if (popped_q != MAX_POP) begin
            popped_d = popped_q + CW'(1);
         end
      end
   end

   // Control state, counters and read-in-flight tracking
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q     <= IDLE;
         burst_len_q <= '0;
         remaining_q <= '0;
         popped_q    <= '0;
         in_flight_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_len_q <= burst_len_d;
         remaining_q <= remaining_d;
         popped_q    <= popped_d;
         in_flight_q <= rdreq_c;
      end
   end

`ifdef LIFO_POP_LAST_EN
   logic last_pend_q;

   // Remember that the request just issued took the final word of a sized burst
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         last_pend_q <= 1'b0;
      end else begin
         last_pend_q <= rdreq_c & !unlimited & (remaining_q == CW'(1));
      end
   end

   // Arriving word is last if it closed a sized burst or it emptied the LIFO
   assign skid_wdata = {last_pend_q | lifo_empty_i, lifo_q_i};
   assign out_last_o = skid_rdata[DWIDTH] & skid_valid;
`else
   assign skid_wdata = lifo_q_i;
`endif

   lifo_skid_buf #(
      .DWIDTH (SW)
   ) u_skid (
      .clk_i       (clk_i),
      .srst_i      (srst_i),
      .wr_i        (in_flight_q),
      .data_i      (skid_wdata),
      .valid_o     (skid_valid),
      .data_o      (skid_rdata),
      .ready_i     (out_ready_i),
      .occupancy_o (skid_occ)
   );

   assign out_data_o   = skid_rdata[DWIDTH-1:0];
   assign out_valid_o  = skid_valid;
   assign lifo_rdreq_o = rdreq_c;
   assign done_o       = done_c;
   assign busy_o       = (state_q != IDLE);
   assign popped_o     = popped_q;

endmodule : lifo_pop_streamer

// File: tb/tb_lifo_pop_streamer.sv
// Directed bench for lifo_pop_streamer with a behavioural LIFO and a stream scoreboard.
// Optional feature macro: LIFO_POP_LAST_EN (also checks out_last_o).
module tb_lifo_pop_streamer;

   logic       clk = 1'b0;
   logic       srst_i;
   logic       start_i;
   logic [3:0] burst_len_i;
   logic       lifo_empty_i;
   logic [7:0] lifo_q_i;
   logic       lifo_rdreq_o;
   logic [7:0] out_data_o;
   logic       out_valid_o;
   logic       out_ready_i;
   logic       busy_o;
   logic       done_o;
   logic [3:0] popped_o;
`ifdef LIFO_POP_LAST_EN
   logic       out_last_o;
`endif

   // Behavioural LIFO environment
   logic       push_en;
   logic [7:0] push_data;
   logic       lifo_clr;
   logic [7:0] mem [16];
   logic [4:0] lcnt;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int hs_cnt   = 0;
   int pop_cnt  = 0;
   int outstanding = 0;
   logic       held_v = 1'b0;
   logic [7:0] held_d = '0;
   logic [8:0] exp_q[$];
   logic [7:0] stack_q[$];

   always #5 clk = ~clk;

   lifo_pop_streamer #(.DWIDTH(8), .AWIDTH(3)) dut (
      .clk_i        (clk),
      .srst_i       (srst_i),
      .start_i      (start_i),
      .burst_len_i  (burst_len_i),
      .lifo_empty_i (lifo_empty_i),
      .lifo_q_i     (lifo_q_i),
      .lifo_rdreq_o (lifo_rdreq_o),
      .out_data_o   (out_data_o),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
`ifdef LIFO_POP_LAST_EN
      .out_last_o   (out_last_o),
`endif
      .busy_o       (busy_o),
      .done_o       (done_o),
      .popped_o     (popped_o)
   );

   // LIFO: registered count, one-cycle read latency
   always @(posedge clk) begin
      if (lifo_clr) begin
         lcnt <= '0;
      end else if (push_en) begin
         mem[lcnt[3:0]] <= push_data;
         lcnt <= lcnt + 5'd1;
      end else if (lifo_rdreq_o && lcnt != '0) begin
         lifo_q_i <= mem[4'(lcnt - 5'd1)];
         lcnt <= lcnt - 5'd1;
      end
   end
   assign lifo_empty_i = (lcnt == '0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: sample at negedge, score handshakes, return just after the next posedge
   task automatic step();
      logic [8:0] e;
      int hs;
      @(negedge clk);
      hs = 0;
      if (lifo_rdreq_o) begin
         chk("credit", 32'(outstanding <= 1), 32'd1);
         pop_cnt++;
      end
      if (held_v) begin
         chk("hold_valid", 32'(out_valid_o), 32'd1);
         chk("hold_data", 32'(out_data_o), 32'(held_d));
      end
      if (out_valid_o && out_ready_i) begin
         hs = 1;
         hs_cnt++;
         if (exp_q.size() == 0) begin
            chk("extra_word", 32'(out_data_o), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("data", 32'(out_data_o), 32'(e[7:0]));
`ifdef LIFO_POP_LAST_EN
            chk("last", 32'(out_last_o), 32'(e[8]));
`endif
         end
      end
      if (done_o) done_cnt++;
      held_v = out_valid_o & !out_ready_i;
      held_d = out_data_o;
      outstanding = outstanding + (lifo_rdreq_o ? 1 : 0) - hs;
      if (srst_i) begin
         outstanding = 0;
         held_v = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         push_en   = 1'b1;
         push_data = base + 8'(i);
         step();
         stack_q.push_back(base + 8'(i));
      end
      push_en = 1'b0;
   endtask

   // Expected words are the top of the shadow stack, last-pushed first
   task automatic start_burst(input int len);
      int k;
      logic [7:0] w;
      k = (len == 0 || len > stack_q.size()) ? stack_q.size() : len;
      for (int i = 0; i < k; i++) begin
         w = stack_q.pop_back();
         exp_q.push_back({(i == k - 1), w});
      end
      start_i     = 1'b1;
      burst_len_i = 4'(len);
      step();
      start_i     = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < max_cycles) begin
         step();
         n++;
      end
      chk("done_timeout", 32'(done_cnt != d0), 32'd1);
   endtask

   initial begin
      int d0;
      srst_i      = 1'b1;
      start_i     = 1'b0;
      burst_len_i = '0;
      out_ready_i = 1'b1;
      push_en     = 1'b0;
      push_data   = '0;
      lifo_clr    = 1'b1;
      repeat (3) step();
      srst_i   = 1'b0;
      lifo_clr = 1'b0;
      step();
      chk("rst_busy",   32'(busy_o),       32'd0);
      chk("rst_done",   32'(done_o),       32'd0);
      chk("rst_valid",  32'(out_valid_o),  32'd0);
      chk("rst_rdreq",  32'(lifo_rdreq_o), 32'd0);
      chk("rst_popped", 32'(popped_o),     32'd0);
      chk("rst_data",   32'(out_data_o),   32'd0);

      // 1: three words, sized burst, sink always ready
      load(3, 8'd1);
      hs_cnt = 0;
      d0 = done_cnt;
      start_burst(3);
      chk("t1_busy",  32'(busy_o),       32'd1);
      chk("t1_rdreq", 32'(lifo_rdreq_o), 32'd1);
      chk("t1_valid_early", 32'(out_valid_o), 32'd0);
      step();
      chk("t1_valid_lat", 32'(out_valid_o), 32'd1);
      chk("t1_first",     32'(out_data_o),  32'd3);
      repeat (3) step();
      chk("t1_b2b", 32'(hs_cnt), 32'd3);
      wait_done(20);
      repeat (3) step();
      chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
      chk("t1_popped",    32'(popped_o),      32'd3);
      chk("t1_busy_end",  32'(busy_o),        32'd0);
      chk("t1_drained",   32'(exp_q.size()),  32'd0);

      // 2: eight words, drain-until-empty, sink toggling
      load(8, 8'h10);
      hs_cnt = 0;
      start_burst(0);
      d0 = done_cnt;
      for (int i = 0; i < 60 && done_cnt == d0; i++) begin
         out_ready_i = ~out_ready_i;
         step();
      end
      chk("t2_done",    32'(done_cnt - d0), 32'd1);
      chk("t2_count",   32'(hs_cnt),        32'd8);
      chk("t2_popped",  32'(popped_o),      32'd8);
      chk("t2_drained", 32'(exp_q.size()),  32'd0);
      out_ready_i = 1'b1;
      step();

      // 3: burst longer than LIFO contents ends early
      load(2, 8'h20);
      hs_cnt = 0;
      start_burst(5);
      wait_done(20);
      chk("t3_count",   32'(hs_cnt),       32'd2);
      chk("t3_popped",  32'(popped_o),     32'd2);
      chk("t3_drained", 32'(exp_q.size()), 32'd0);
      chk("t3_empty",   32'(lifo_empty_i), 32'd1);

      // 4: backpressure right after start limits pops to the skid credit
      load(5, 8'h30);
      out_ready_i = 1'b0;
      start_burst(0);
      pop_cnt = 0;
      repeat (10) step();
      chk("t4_pops",  32'(pop_cnt),     32'd2);
      chk("t4_valid", 32'(out_valid_o), 32'd1);
      chk("t4_head",  32'(out_data_o),  32'h34);
      out_ready_i = 1'b1;
      wait_done(30);
      chk("t4_popped",  32'(popped_o),     32'd5);
      chk("t4_drained", 32'(exp_q.size()), 32'd0);

      // 5: reset with one word stored and one in flight
      load(3, 8'h40);
      out_ready_i = 1'b0;
      start_burst(0);
      step();
      step();
      d0 = done_cnt;
      srst_i = 1'b1;
      step();
      srst_i = 1'b0;
      chk("t5_busy",   32'(busy_o),       32'd0);
      chk("t5_valid",  32'(out_valid_o),  32'd0);
      chk("t5_rdreq",  32'(lifo_rdreq_o), 32'd0);
      chk("t5_done",   32'(done_o),       32'd0);
      chk("t5_popped", 32'(popped_o),     32'd0);
      chk("t5_data",   32'(out_data_o),   32'd0);
      exp_q.delete();
      stack_q.delete();
      lifo_clr = 1'b1;
      step();
      lifo_clr = 1'b0;
      repeat (4) step();
      chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
      chk("t5_idle",    32'(busy_o),        32'd0);
      out_ready_i = 1'b1;

      // 6: sized burst with a start while busy, then drain the remainder
      load(6, 8'h50);
      start_burst(4);
      step();
      start_i     = 1'b1;
      burst_len_i = 4'd0;
      step();
      step();
      start_i = 1'b0;
      wait_done(20);
      chk("t6_popped",   32'(popped_o),     32'd4);
      chk("t6_drained",  32'(exp_q.size()), 32'd0);
      chk("t6_lifo_left", 32'(lcnt),        32'd2);
      step();
      start_burst(0);
      wait_done(20);
      chk("t6_rest_popped",  32'(popped_o),     32'd2);
      chk("t6_rest_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lifo_pop_streamer
